// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider.
//   div_state_e : FSM state encoding
//   DIV_CYCLES  : quotient bits produced, one per cycle in ON
//   neg_if      : conditional two's-complement negate
package div_unit_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BYZERO = 2'b01,
        ON     = 2'b10,
        END    = 2'b11
    } div_state_e;

    localparam int DIV_CYCLES = 32;

    function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_unit_step.sv
// One radix-2 restoring division step (combinational).
//   rem_i     : partial remainder so far (always < divisor_i)
//   dvd_msb_i : next dividend bit shifted in
//   divisor_i : divisor magnitude
//   rem_o     : next partial remainder
//   qbit_o    : quotient bit produced by this step
module div_step (
    input  logic [31:0] rem_i,
    input  logic        dvd_msb_i,
    input  logic [31:0] divisor_i,
    output logic [31:0] rem_o,
    output logic        qbit_o
);

    logic [32:0] partial;
    logic [32:0] trial;

    assign partial = {rem_i, dvd_msb_i};
    // Since rem_i < divisor_i, partial - divisor lies in (-2^32, 2^32),
    // so bit 32 of the 33-bit difference is exactly the "went negative" flag.
    assign trial   = partial - {1'b0, divisor_i};
    assign qbit_o  = ~trial[32];
    assign rem_o   = qbit_o ? trial[31:0] : partial[31:0];

endmodule

// File: rtl/div_unit.sv
// Multi-cycle 32-bit signed/unsigned divider for the EX stage.
//   clk, rst          : clock, async active-high reset
//   div_start         : divide request, held by EX until ready
//   signed_div        : 1 = DIV, 0 = DIVU
//   dividend, divisor : operands, sampled on accept only
//   annul             : flush an in-flight operation
//   result_lo/hi      : quotient / remainder
//   ready             : one-cycle result-valid pulse
//   stallreq_from_ex  : pipeline stall request
module div_unit
    import div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        div_start,
    input  logic        signed_div,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        annul,
    output logic [31:0] result_lo,
    output logic [31:0] result_hi,
    output logic        ready,
    output logic        stallreq_from_ex
);

    div_state_e  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] dvd_q, dvd_d;   // dividend magnitude, becomes quotient as bits shift in
    logic [31:0] dvs_q, dvs_d;   // divisor magnitude
    logic [31:0] rem_q, rem_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] hi_q, hi_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;

    logic        accept;
    logic [31:0] step_rem;
    logic        step_qbit;

    div_step u_step (
        .rem_i     (rem_q),
        .dvd_msb_i (dvd_q[31]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .qbit_o    (step_qbit)
    );

    assign accept           = (state_q == IDLE) && div_start && !annul;
    assign ready            = (state_q == END);
    assign stallreq_from_ex = div_start && !ready;
    assign result_lo        = lo_q;
    assign result_hi        = hi_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    dvd_d     = neg_if(signed_div && dividend[31], dividend);
                    dvs_d     = neg_if(signed_div && divisor[31], divisor);
                    neg_quo_d = signed_div && (dividend[31] ^ divisor[31]);
                    neg_rem_d = signed_div && dividend[31];
                    rem_d     = '0;
                    cnt_d     = '0;
                    state_d   = (divisor == 32'd0) ? BYZERO : ON;
                end
            end
            BYZERO: begin
                if (annul) begin
                    state_d = IDLE;
                end else begin
                    lo_d    = '0;
                    hi_d    = '0;
                    state_d = END;
                end
            end
            ON: begin
                if (annul) begin
                    state_d = IDLE;
                end else begin
                    rem_d = step_rem;
                    dvd_d = {dvd_q[30:0], step_qbit};
                    cnt_d = cnt_q + 6'd1;
                    // Last iteration: commit sign-corrected results so they
                    // are stable for the whole END cycle.
                    if (cnt_q == 6'(DIV_CYCLES - 1)) begin
                        lo_d    = neg_if(neg_quo_q, {dvd_q[30:0], step_qbit});
                        hi_d    = neg_if(neg_rem_q, step_rem);
                        state_d = END;
                    end
                end
            end
            END: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            lo_q      <= '0;
            hi_q      <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        div_start;
    logic        signed_div;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        annul;
    logic [31:0] result_lo;
    logic [31:0] result_hi;
    logic        ready;
    logic        stallreq_from_ex;

    div_unit dut (
        .clk              (clk),
        .rst              (rst),
        .div_start        (div_start),
        .signed_div       (signed_div),
        .dividend         (dividend),
        .divisor          (divisor),
        .annul            (annul),
        .result_lo        (result_lo),
        .result_hi        (result_hi),
        .ready            (ready),
        .stallreq_from_ex (stallreq_from_ex)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] lo;
        logic [31:0] hi;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_lo = 32'd0;
    logic [31:0] last_hi = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: got ready=1 lo=0x%08h hi=0x%08h expected no ready",
                         result_lo, result_hi);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("result_lo", result_lo, e.lo);
                chk("result_hi", result_hi, e.hi);
            end
        end
    end

    // Count cycles until ready, checking stall is high on every cycle before it.
    task automatic wait_ready(input bit scramble, output int n, output bit stall_ok);
        n = 0;
        stall_ok = 1'b1;
        while (!ready && n < 100) begin
            if (!stallreq_from_ex) stall_ok = 1'b0;
            @(posedge clk); #1;
            n++;
            if (scramble && n == 1) begin
                dividend   = 32'hDEADBEEF;
                divisor    = 32'h00000003;
                signed_div = ~signed_div;
            end
        end
    endtask

    task automatic run_div(input string name, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input int exp_lat,
                           input logic [31:0] elo, input logic [31:0] ehi, input bit annul_end);
        int n;
        bit stall_ok;
        sb_q.push_back('{lo: elo, hi: ehi});
        @(posedge clk); #1;
        div_start  = 1'b1;
        signed_div = sgn;
        dividend   = a;
        divisor    = b;
        #1;
        wait_ready(1'b1, n, stall_ok);
        chk({name, "_latency"}, 32'(n), 32'(exp_lat));
        chk({name, "_stall_busy"}, {31'd0, stall_ok}, 32'd1);
        chk({name, "_stall_end"}, {31'd0, stallreq_from_ex}, 32'd0);
        if (annul_end) begin
            annul = 1'b1;
            #1;
            chk({name, "_ready_despite_annul"}, {31'd0, ready}, 32'd1);
        end
        div_start = 1'b0;
        last_lo = elo;
        last_hi = ehi;
        @(posedge clk); #1;
        annul = 1'b0;
    endtask

    initial begin
        int n;
        bit stall_ok;
        rst = 1'b1; div_start = 1'b0; signed_div = 1'b0;
        dividend = 32'd0; divisor = 32'd0; annul = 1'b0;
        #1;
        chk("reset_lo", result_lo, 32'd0);
        chk("reset_hi", result_hi, 32'd0);
        chk("reset_ready", {31'd0, ready}, 32'd0);
        chk("reset_stall", {31'd0, stallreq_from_ex}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_div("u100_7",    1'b0, 32'd100,        32'd7,          33, 32'd14,         32'd2,          1'b0);
        run_div("s-7_2",     1'b1, 32'hFFFFFFF9,   32'd2,          33, 32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0);
        run_div("s7_-2",     1'b1, 32'd7,          32'hFFFFFFFE,   33, 32'hFFFFFFFD,   32'd1,          1'b0);
        run_div("s-9_-4",    1'b1, 32'hFFFFFFF7,   32'hFFFFFFFC,   33, 32'd2,          32'hFFFFFFFF,   1'b1);
        run_div("byzero",    1'b0, 32'h00001234,   32'd0,          2,  32'd0,          32'd0,          1'b0);
        run_div("s_minovf",  1'b1, 32'h80000000,   32'hFFFFFFFF,   33, 32'h80000000,   32'd0,          1'b0);
        run_div("u_minovf",  1'b0, 32'h80000000,   32'hFFFFFFFF,   33, 32'd0,          32'h80000000,   1'b0);
        run_div("u_max_1",   1'b0, 32'hFFFFFFFF,   32'd1,          33, 32'hFFFFFFFF,   32'd0,          1'b0);

        // Annul at cycle 10: no ready, results untouched.
        @(posedge clk); #1;
        div_start = 1'b1; signed_div = 1'b0; dividend = 32'd100; divisor = 32'd7;
        repeat (10) begin @(posedge clk); #1; end
        annul = 1'b1; div_start = 1'b0;
        @(posedge clk); #1;
        annul = 1'b0;
        chk("annul_ready", {31'd0, ready}, 32'd0);
        chk("annul_stall", {31'd0, stallreq_from_ex}, 32'd0);
        repeat (40) begin @(posedge clk); #1; end
        chk("annul_lo_kept", result_lo, last_lo);
        chk("annul_hi_kept", result_hi, last_hi);

        // Back-to-back with start held high.
        sb_q.push_back('{lo: 32'd100, hi: 32'd0});
        sb_q.push_back('{lo: 32'hFFFFFFF2, hi: 32'hFFFFFFFE});
        @(posedge clk); #1;
        div_start = 1'b1; signed_div = 1'b0; dividend = 32'd1000; divisor = 32'd10;
        #1;
        wait_ready(1'b0, n, stall_ok);
        chk("b2b_first_latency", 32'(n), 32'd33);
        signed_div = 1'b1; dividend = 32'hFFFFFF9C; divisor = 32'd7;
        @(posedge clk); #1;
        wait_ready(1'b0, n, stall_ok);
        chk("b2b_spacing", 32'(n + 1), 32'd34);
        chk("b2b_stall", {31'd0, stall_ok}, 32'd1);
        div_start = 1'b0;
        @(posedge clk); #1;

        // Reset mid-operation at cycle 20.
        div_start = 1'b1; signed_div = 1'b0; dividend = 32'd999; divisor = 32'd5;
        repeat (20) begin @(posedge clk); #1; end
        rst = 1'b1; div_start = 1'b0;
        #1;
        chk("midrst_lo", result_lo, 32'd0);
        chk("midrst_hi", result_hi, 32'd0);
        chk("midrst_ready", {31'd0, ready}, 32'd0);
        chk("midrst_stall", {31'd0, stallreq_from_ex}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (40) begin @(posedge clk); #1; end
        chk("postrst_ready", {31'd0, ready}, 32'd0);

        run_div("u45_6",     1'b0, 32'd45,         32'd6,          33, 32'd7,          32'd3,          1'b0);

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
